// File: rtl/hellow_world_cpu_cpu_debug_mem_master.sv
// Debug memory master: converts ocimem command strobes from the JTAG debug
// slave into single Avalon-MM word reads/writes. It reports the read data on
// MonDReg and the command status on monitor_ready and monitor_error.
//
// Ports
//   clk, reset_n                  system clock, async active-low reset
//   jdo[37:0]                     command payload, stable while a strobe is high
//   take_action_ocimem_a          load address (jdo addr field); read if jdo[34]
//   take_action_ocimem_b          write jdo[34:3] at current address
//   take_no_action_ocimem_a       read at current address
//   MonDReg                       last read data
//   monitor_ready / monitor_error idle flag / sticky error for last command
//   avm_*                         Avalon-MM master port (word-aligned byte address)
module hellow_world_cpu_cpu_debug_mem_master #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic [ADDR_W+1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_LSB = 17;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   mon_q, mon_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                ready_q, ready_d;
  logic                err_q, err_d;
  logic                read_q, read_d;
  logic                write_q, write_d;
  logic                any_strobe_c;

  // jdo bits outside the address/data fields are not used by this block
  logic jdo_unused;
  assign jdo_unused = ^{jdo[37:35], jdo[2:0]};

  assign any_strobe_c = take_action_ocimem_a | take_action_ocimem_b |
                        take_no_action_ocimem_a;

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    mon_d   = mon_q;
    wdata_d = wdata_q;
    ready_d = ready_q;
    err_d   = err_q;
    read_d  = read_q;
    write_d = write_q;

    unique case (state_q)
      ST_IDLE: begin
        // Strobe priority: ocimem_a > ocimem_b > no_action_a
        if (take_action_ocimem_a) begin
          addr_d = jdo[ADDR_LSB +: ADDR_W];
          err_d  = 1'b0;
          if (jdo[34]) begin
            state_d = ST_RD;
            read_d  = 1'b1;
            ready_d = 1'b0;
          end
        end else if (take_action_ocimem_b) begin
          wdata_d = jdo[34:3];
          state_d = ST_WR;
          write_d = 1'b1;
          ready_d = 1'b0;
          err_d   = 1'b0;
        end else if (take_no_action_ocimem_a) begin
          state_d = ST_RD;
          read_d  = 1'b1;
          ready_d = 1'b0;
          err_d   = 1'b0;
        end
      end

      ST_RD, ST_WR: begin
        // A new command while busy is dropped but flagged
        if (any_strobe_c) begin
          err_d = 1'b1;
        end
        if (!avm_waitrequest) begin
          if (state_q == ST_RD) begin
            mon_d = avm_readdata;
          end
          addr_d  = addr_q + ADDR_W'(1);
          read_d  = 1'b0;
          write_d = 1'b0;
          ready_d = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          // This stalled cycle is the TIMEOUT_CYC-th one: abort
          read_d  = 1'b0;
          write_d = 1'b0;
          ready_d = 1'b1;
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        read_d  = 1'b0;
        write_d = 1'b0;
        ready_d = 1'b1;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      mon_q   <= '0;
      wdata_q <= '0;
      ready_q <= 1'b1;
      err_q   <= 1'b0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      mon_q   <= mon_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      read_q  <= read_d;
      write_q <= write_d;
    end
  end

  assign MonDReg        = mon_q;
  assign monitor_ready  = ready_q;
  assign monitor_error  = err_q;
  assign avm_address    = {addr_q, 2'b00};
  assign avm_read       = read_q;
  assign avm_write      = write_q;
  assign avm_writedata  = wdata_q;
  assign avm_byteenable = 4'hF;

endmodule
